// File: rtl/rng_stimulus_bank.sv
// Purpose: per-channel LFSR stimulus source with run/step control, plus MISR and word capture of DUT results.
// Latency: stimulus advances one vector per accepted cycle; sig/data update on the edge after dut_valid.
// Backpressure: LFSRs and vec_count hold while stim_valid && !stim_ready; result capture never stalls.
module rng_stimulus_bank #(
    parameter int          NUM_CH    = 16,
    parameter int          DATA_W    = 18,
    parameter int          NUM_OUT   = 32,
    parameter logic [31:0] SEED_BASE = 32'd0,
    parameter int          VEC_LIMIT = 0,
    localparam int         SEL_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        replay,
    input  logic                        step_mode,
    output logic [NUM_CH*DATA_W-1:0]    stim_data,
    output logic                        stim_valid,
    input  logic                        stim_ready,
    input  logic [NUM_OUT*DATA_W-1:0]   dut_data,
    input  logic                        dut_valid,
    input  logic [SEL_W-1:0]            out_sel,
    output logic [DATA_W-1:0]           data,
    output logic [31:0]                 sig,
    output logic [31:0]                 vec_count,
    output logic                        done
);

    typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;

    state_t      state;
    logic [31:0] lfsr [NUM_CH];
    logic        accept;
    logic [31:0] count_inc;
    logic        limit_hit;
    logic [31:0] fold;
    logic [DATA_W-1:0] sel_word;

    function automatic logic [31:0] seed_of(input int ch);
        logic [31:0] s;
        s = SEED_BASE * 32'(NUM_CH) + 32'(ch) + 32'd1;
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    assign accept    = stim_valid && stim_ready;
    assign count_inc = vec_count + 32'd1;
    assign limit_hit = (VEC_LIMIT != 0) && (count_inc == 32'(VEC_LIMIT));

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign stim_data[ch*DATA_W +: DATA_W] = lfsr[ch][DATA_W-1:0];
    end

    // Reset and replay share one path: both discard any acceptance in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst || replay) begin
            state      <= IDLE;
            stim_valid <= 1'b0;
            done       <= 1'b0;
            vec_count  <= 32'd0;
            for (int ch = 0; ch < NUM_CH; ch++) lfsr[ch] <= seed_of(ch);
        end else begin
            if (accept) begin
                vec_count <= count_inc;
                for (int ch = 0; ch < NUM_CH; ch++) lfsr[ch] <= lfsr_next(lfsr[ch]);
            end
            case (state)
                IDLE: begin
                    if (!stop && start) begin
                        state      <= step_mode ? STEP : RUN;
                        stim_valid <= 1'b1;
                    end
                end
                RUN, STEP: begin
                    if (accept && limit_hit) begin
                        state      <= DONE;
                        stim_valid <= 1'b0;
                        done       <= 1'b1;
                    end else if (stop || (state == STEP && accept)) begin
                        state      <= IDLE;
                        stim_valid <= 1'b0;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state      <= IDLE;
                    stim_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fold     = 32'd0;
        sel_word = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            fold = fold ^ 32'(dut_data[i*DATA_W +: DATA_W]);
            if (out_sel == SEL_W'(i)) sel_word = dut_data[i*DATA_W +: DATA_W];
        end
    end

    // Result capture runs regardless of FSM state; out-of-range selects yield zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sig  <= 32'd0;
            data <= '0;
        end else begin
            if (replay) begin
                sig <= 32'd0;
            end else if (dut_valid) begin
                sig <= {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
            end
            if (dut_valid) data <= sel_word;
        end
    end

endmodule

// File: doc/rng_stimulus_bank.md
RNG_STIMULUS_BANK -- requirements
Module: rng_stimulus_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: number of stimulus channels.
REQ-002 SHALL have parameter DATA_W, default 18: width per channel and per DUT output word; legal range 1..32.
REQ-003 SHALL have parameter NUM_OUT, default 32: number of DUT result words.
REQ-004 SHALL have parameter SEED_BASE, default 0: 32-bit seed offset.
REQ-005 SHALL have parameter VEC_LIMIT, default 0: vectors per run; 0 means unlimited.
REQ-006 SHALL have one clock; reset is synchronous and active-low.
REQ-007 Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  pulse, begin run or step.
- stop  in  1  pulse, abort run.
- replay  in  1  pulse, reload seeds, clear counters.
- step_mode  in  1  0 = free-run, 1 = single vector per start.
- stim_data  out  NUM_CH*DATA_W  channel ch at bits [ch*DATA_W +: DATA_W].
- stim_valid  out  1  stimulus offered.
- stim_ready  in  1  DUT accepts stimulus.
- dut_data  in  NUM_OUT*DATA_W  DUT results, packed like stim_data.
- dut_valid  in  1  dut_data valid this cycle.
- out_sel  in  clog2(NUM_OUT)  result word to expose.
- data  out  DATA_W  registered selected result.
- sig  out  32  MISR signature.
- vec_count  out  32  accepted vectors.
- done  out  1  VEC_LIMIT reached.

Function
REQ-008 Each channel SHALL hold a 32-bit Fibonacci LFSR, next = {s[30:0], s[31]^s[21]^s[1]^s[0]}; channel output = s[DATA_W-1:0].
REQ-009 Seed of channel ch SHALL be (SEED_BASE*NUM_CH + ch + 1) mod 2^32; a zero result SHALL be replaced by 1.
REQ-010 Handshake: a vector is accepted in a cycle where stim_valid && stim_ready.
- On acceptance, all LFSRs advance once and vec_count increments.
- LFSRs otherwise hold, so stim_data is stable while stim_valid && !stim_ready.
REQ-011 FSM states SHALL be IDLE, RUN, STEP, DONE; stim_valid = 1 only in RUN and STEP.
REQ-012 IDLE: start -> STEP if step_mode = 1, else RUN.
REQ-013 RUN: stop -> IDLE; an acceptance making vec_count equal VEC_LIMIT (VEC_LIMIT != 0) -> DONE.
REQ-014 STEP: on acceptance -> IDLE (or DONE if VEC_LIMIT reached); stop -> IDLE.
REQ-015 DONE: done = 1; start and stop ignored.
REQ-016 replay in any state SHALL reload all seeds, clear vec_count, done and sig to 0, and go to IDLE next cycle.
REQ-017 Priority: replay > stop > start.
- An acceptance in the same cycle as stop SHALL still count and advance.
- An acceptance in the same cycle as replay SHALL be discarded.
REQ-018 start while in RUN or STEP SHALL be ignored.
REQ-019 vec_count SHALL wrap from 2^32-1 to 0 when VEC_LIMIT = 0.
REQ-020 MISR, on each dut_valid cycle: sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ F.
- F = XOR of all NUM_OUT words, each zero-extended to 32 bits.
- sig SHALL hold when dut_valid = 0.
REQ-021 On each dut_valid cycle, data <= word out_sel of dut_data, or 0 if out_sel >= NUM_OUT; data SHALL hold otherwise.
REQ-022 dut_valid SHALL be honoured in every state, independent of the FSM.

Reset
REQ-023 While rst = 0 at a clock edge, the block SHALL:
- go to IDLE and reload seeds;
- drive stim_valid = 0, done = 0, vec_count = 0, sig = 0, data = 0.
REQ-024 Reset asserted mid-RUN SHALL discard any acceptance in that cycle.

Verification
REQ-025 Defaults, reset release -> stim_valid = 0, ch0 = 0x00001, ch1 = 0x00002; start with stim_ready = 1 -> ch0 sequence 0x00001, 0x00003, 0x00006, 0x0000D; ch1 second value 0x00005.
REQ-026 RUN with stim_ready = 0 for 3 cycles -> ch0 held at 0x00001, vec_count = 0; stim_ready = 1 -> ch0 = 0x00003 next cycle.
REQ-027 VEC_LIMIT = 4, free-run, stim_ready = 1 -> after 4 acceptances done = 1, stim_valid = 0, vec_count = 4; replay -> done = 0, ch0 = 0x00001.
REQ-028 step_mode = 1, start -> exactly one acceptance, vec_count = 1, then IDLE with stim_valid = 0.
REQ-029 MISR from 0, two dut_valid cycles with word0 = 0x00005 and all other words 0 -> sig = 0x00000005 then 0x0000000F; out_sel = 0 -> data = 0x00005.
REQ-030 rst = 0 mid-RUN with stim_ready = 1 -> next cycle stim_valid = 0, vec_count = 0, ch0 = 0x00001; stop and start in the same cycle -> IDLE.
